// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding and counter sizing for the clock timebase.
package clock_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    S_WAIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clock_timebase_if.sv
// clock_timebase_if: lock/enable inputs and reset/strobe outputs of the timebase.
interface clock_timebase_if;
  import clock_pkg::*;
  logic               locked;
  logic               en;
  logic               rstOut;
  logic               tick;
  logic               tickSlow;
  logic [STATE_W-1:0] state;
  modport master (output locked, en, input rstOut, tick, tickSlow, state);
  modport slave  (input locked, en, output rstOut, tick, tickSlow, state);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for asynchronous inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic meta_d, sync_d;
  always_comb begin
    meta_d = rst ? 1'b0 : d;
    sync_d = rst ? 1'b0 : meta_q;
  end
  always_ff @(posedge clk) begin
    meta_q <= meta_d;
    sync_q <= sync_d;
  end
  assign q = sync_q;
endmodule

// File: rtl/clock_timebase.sv
// clock_timebase: holds downstream reset until MMCM lock is stable, then emits base and slow ticks.
module clock_timebase
  import clock_pkg::*;
#(
  parameter int C_CLK_FRQ   = 10_000_000,
  parameter int C_TICK_FRQ  = 1_000,
  parameter int C_SLOW_DIV  = 1_000,
  parameter int C_LOCK_WAIT = 1024
) (
  input logic              clk,
  input logic              rst,
  clock_timebase_if.slave  bus
);
  localparam int C_DIV  = C_CLK_FRQ / C_TICK_FRQ;
  localparam int DIV_W  = cnt_w(C_DIV);
  localparam int SLOW_W = cnt_w(C_SLOW_DIV);
  localparam int LOCK_W = cnt_w(C_LOCK_WAIT);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(C_DIV - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(C_SLOW_DIV - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(C_LOCK_WAIT - 1);
  if ((C_CLK_FRQ % C_TICK_FRQ) != 0 || C_DIV < 2 || C_SLOW_DIV < 1 || C_LOCK_WAIT < 1) begin : g_param_err
    $error("clock_timebase: invalid parameter set");
  end
  logic lock_s;
  sync_2ff u_lock_sync (.clk(clk), .rst(rst), .d(bus.locked), .q(lock_s));
  state_t              state_q, state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [SLOW_W-1:0]   slow_cnt_q, slow_cnt_d;
  logic                rst_out_q, rst_out_d;
  logic                tick_q, tick_d;
  logic                tick_slow_q, tick_slow_d;
  logic                stay_run, step, wrap;
  // Unused encoding 3 falls into the S_WAIT branch.
  always_comb begin
    state_d     = state_q == S_RUN   ? (lock_s ? S_RUN : S_FAULT) :
                  state_q == S_FAULT ? S_WAIT :
                  (lock_s && lock_cnt_q == LOCK_LAST) ? S_RUN : S_WAIT;
    stay_run    = state_q == S_RUN && state_d == S_RUN;
    step        = stay_run && bus.en;
    wrap        = step && div_cnt_q == DIV_LAST;
    lock_cnt_d  = (state_q != S_FAULT && state_d == S_WAIT && lock_s) ? lock_cnt_q + LOCK_W'(1) : '0;
    div_cnt_d   = (!stay_run || wrap) ? '0 : step ? div_cnt_q + DIV_W'(1) : div_cnt_q;
    slow_cnt_d  = !stay_run ? '0 : !wrap ? slow_cnt_q : slow_cnt_q == SLOW_LAST ? '0 : slow_cnt_q + SLOW_W'(1);
    tick_d      = wrap;
    tick_slow_d = wrap && slow_cnt_q == SLOW_LAST;
    rst_out_d   = state_d != S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT;
      lock_cnt_q  <= '0;
      div_cnt_q   <= '0;
      slow_cnt_q  <= '0;
      rst_out_q   <= 1'b1;
      tick_q      <= 1'b0;
      tick_slow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      div_cnt_q   <= div_cnt_d;
      slow_cnt_q  <= slow_cnt_d;
      rst_out_q   <= rst_out_d;
      tick_q      <= tick_d;
      tick_slow_q <= tick_slow_d;
    end
  end
  assign bus.rstOut   = rst_out_q;
  assign bus.tick     = tick_q;
  assign bus.tickSlow = tick_slow_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_clock_timebase.sv
// tb_clock_timebase: directed and random checks of clock_timebase against an event-level model.
module tb_clock_timebase;
  import clock_pkg::*;
  localparam int CLK_FRQ = 1000, TICK_FRQ = 100, SLOW = 5, LW = 8, DIV = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  clock_timebase_if bus ();
  clock_timebase #(.C_CLK_FRQ(CLK_FRQ), .C_TICK_FRQ(TICK_FRQ), .C_SLOW_DIV(SLOW), .C_LOCK_WAIT(LW))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, passed = 0;
  int m_mode, m_stable, m_en_cnt;
  bit m_s1, m_s2, e_rst_out, e_tick, e_slow;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // Mode follows spec numbering; ticks derive from a single count of enabled run cycles.
  task automatic model_step();
    bit ls;
    ls = m_s2;
    e_tick = 0;
    e_slow = 0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_mode = 0; m_stable = 0; m_en_cnt = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = bus.locked;
      if (m_mode == 1) begin
        if (!ls) begin
          m_mode = 2;
          m_en_cnt = 0;
        end else if (bus.en) begin
          m_en_cnt++;
          e_tick = (m_en_cnt % DIV) == 0;
          e_slow = (m_en_cnt % (DIV * SLOW)) == 0;
        end
      end else if (m_mode == 2) begin
        m_mode = 0;
      end else begin
        m_stable = ls ? m_stable + 1 : 0;
        if (m_stable == LW) begin
          m_mode = 1;
          m_stable = 0;
          m_en_cnt = 0;
        end
      end
    end
    e_rst_out = m_mode != 1;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(bus.state), 32'(m_mode));
    chk("rstOut", 32'(bus.rstOut), 32'(e_rst_out));
    chk("tick", 32'(bus.tick), 32'(e_tick));
    chk("tickSlow", 32'(bus.tickSlow), 32'(e_slow));
  endtask
  initial begin
    bus.locked = 1'b1;
    bus.en = 1'b1;
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_rstOut", 32'(bus.rstOut), 32'd1);
    chk("reset_state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    repeat (9) cyc();
    chk("hold_before_release", 32'(bus.rstOut), 32'd1);
    cyc();
    chk("release", 32'(bus.rstOut), 32'd0);
    chk("run_state", 32'(bus.state), 32'd1);
    repeat (9) cyc();
    chk("no_early_tick", 32'(bus.tick), 32'd0);
    cyc();
    chk("first_tick", 32'(bus.tick), 32'd1);
    chk("first_tick_not_slow", 32'(bus.tickSlow), 32'd0);
    repeat (40) cyc();
    chk("fifth_tick", 32'(bus.tick), 32'd1);
    chk("slow_tick", 32'(bus.tickSlow), 32'd1);
    for (int i = 0; i < 40 && (m_en_cnt % DIV) != 4; i++) cyc();
    bus.en = 1'b0;
    repeat (7) begin
      cyc();
      chk("no_tick_en0", 32'(bus.tick), 32'd0);
    end
    bus.en = 1'b1;
    repeat (5) cyc();
    chk("held_no_tick", 32'(bus.tick), 32'd0);
    cyc();
    chk("held_tick_resumes", 32'(bus.tick), 32'd1);
    bus.locked = 1'b0;
    repeat (2) cyc();
    chk("drop_still_run", 32'(bus.state), 32'd1);
    cyc();
    chk("fault_state", 32'(bus.state), 32'd2);
    chk("fault_rstOut", 32'(bus.rstOut), 32'd1);
    chk("fault_tick", 32'(bus.tick), 32'd0);
    cyc();
    chk("after_fault_wait", 32'(bus.state), 32'd0);
    bus.locked = 1'b1;
    repeat (9) cyc();
    chk("relock_hold", 32'(bus.rstOut), 32'd1);
    cyc();
    chk("relock_release", 32'(bus.rstOut), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 40 && m_stable != 5; i++) cyc();
    bus.locked = 1'b0;
    repeat (3) cyc();
    bus.locked = 1'b1;
    repeat (9) cyc();
    chk("glitch_hold", 32'(bus.rstOut), 32'd1);
    cyc();
    chk("glitch_release", 32'(bus.rstOut), 32'd0);
    for (int i = 0; i < 30 && !e_tick; i++) cyc();
    chk("pre_rst_tick", 32'(bus.tick), 32'd1);
    rst = 1'b1;
    cyc();
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_rstOut", 32'(bus.rstOut), 32'd1);
    chk("rst_state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    repeat (9) cyc();
    chk("rst_rewait_hold", 32'(bus.rstOut), 32'd1);
    cyc();
    chk("rst_rewait_release", 32'(bus.rstOut), 32'd0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) bus.locked = ~bus.locked;
      bus.en = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 499) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
